// File: rtl/mmio_rd_tracker.sv
// MMIO read tracker: logs request tids in order, strobes the read slave, pairs
// in-order slave data with the logged tid and forces a zero response on timeout.
module mmio_rd_tracker #(
  parameter int TID_WIDTH  = 9,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64,
  parameter int TIMEOUT    = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  input  logic [TID_WIDTH-1:0]    i_req_tid,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  output logic                    o_slv_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_slv_rd_addr,
  input  logic                    i_slv_rd_valid,
  input  logic [DATA_WIDTH-1:0]   i_slv_rd_data,
  output logic                    o_resp_valid,
  output logic [TID_WIDTH-1:0]    o_resp_tid,
  output logic [DATA_WIDTH-1:0]   o_resp_data,
  output logic [$clog2(DEPTH):0]  o_outstanding,
  output logic [15:0]             o_timeout_cnt,
  output logic                    o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  logic [TID_WIDTH-1:0]  r_tid_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [TW-1:0]         r_timer;
  logic [15:0]           r_drop_cnt;
  logic                  r_slv_rd_en;
  logic [ADDR_WIDTH-1:0] r_slv_rd_addr;
  logic                  r_resp_valid;
  logic [TID_WIDTH-1:0]  r_resp_tid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic [15:0]           r_timeout_cnt;
  logic                  r_overflow;

  logic w_empty;
  logic w_full;
  logic w_slv_pop;
  logic w_discard;
  logic w_expire;
  logic w_pop;
  logic w_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_slv_pop = i_slv_rd_valid && !w_empty && (r_drop_cnt == '0);
  // Data arriving while drops are owed belongs to an entry already answered with zero.
  assign w_discard = i_slv_rd_valid && (r_drop_cnt != '0);
  // Slave data on the expiry cycle wins over the forced zero response.
  assign w_expire  = !w_empty && (r_timer == TW'(TIMEOUT-1)) && !w_slv_pop;
  assign w_pop     = w_slv_pop || w_expire;
  assign w_push    = i_req_valid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tid_mem[r_wr_ptr] <= i_req_tid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_timer       <= '0;
      r_drop_cnt    <= '0;
      r_slv_rd_en   <= 1'b0;
      r_slv_rd_addr <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_tid    <= '0;
      r_resp_data   <= '0;
      r_timeout_cnt <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_slv_rd_en  <= w_push;
      r_resp_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr      <= r_wr_ptr + AW'(1);
        r_slv_rd_addr <= i_req_addr;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_resp_tid  <= r_tid_mem[r_rd_ptr];
        r_resp_data <= w_slv_pop ? i_slv_rd_data : '0;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end
      if (w_pop || w_empty) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
      if (w_expire && !w_discard) begin
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end else if (!w_expire && w_discard) begin
        r_drop_cnt <= r_drop_cnt - 16'd1;
      end
      if (w_expire && (r_timeout_cnt != 16'hFFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 16'd1;
      end
      if (i_req_valid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_slv_rd_en   = r_slv_rd_en;
  assign o_slv_rd_addr = r_slv_rd_addr;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_tid    = r_resp_tid;
  assign o_resp_data   = r_resp_data;
  assign o_outstanding = r_count;
  assign o_timeout_cnt = r_timeout_cnt;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_mmio_rd_tracker.sv
// Scoreboard bench for mmio_rd_tracker with a small FIFO and short timeout,
// driven by an in-order slave model of configurable latency.
module tb_mmio_rd_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic [8:0]  i_req_tid;
  logic [15:0] i_req_addr;
  logic        o_slv_rd_en;
  logic [15:0] o_slv_rd_addr;
  logic        i_slv_rd_valid;
  logic [63:0] i_slv_rd_data;
  logic        o_resp_valid;
  logic [8:0]  o_resp_tid;
  logic [63:0] o_resp_data;
  logic [2:0]  o_outstanding;
  logic [15:0] o_timeout_cnt;
  logic        o_overflow;

  mmio_rd_tracker #(
    .TID_WIDTH(9), .ADDR_WIDTH(16), .DATA_WIDTH(64), .DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_tid(i_req_tid), .i_req_addr(i_req_addr),
    .o_slv_rd_en(o_slv_rd_en), .o_slv_rd_addr(o_slv_rd_addr),
    .i_slv_rd_valid(i_slv_rd_valid), .i_slv_rd_data(i_slv_rd_data),
    .o_resp_valid(o_resp_valid), .o_resp_tid(o_resp_tid), .o_resp_data(o_resp_data),
    .o_outstanding(o_outstanding), .o_timeout_cnt(o_timeout_cnt), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] tid; logic [63:0] data; int due; } exp_t;
  typedef struct { logic [15:0] addr; int due; } sl_t;

  exp_t sb[$];
  sl_t  sl_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   lat = 2;
  bit   silent = 1'b0;
  int   peak = 0;
  int   exp_to = 0;

  function automatic logic [63:0] mkdata(input logic [15:0] a);
    if (a == 16'h0030) return 64'hDEAD_BEEF;
    return {a, ~a, a ^ 16'h5A5A, 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: observe outputs, run the slave model, leave inputs idle.
  task automatic step();
    exp_t e;
    sl_t  s;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    cyc++;
    if (o_resp_valid) begin
      $display("resp cyc=%0d tid=%0h data=%0h", cyc, o_resp_tid, o_resp_data);
      if (sb.size() == 0) begin
        check("spurious_resp", 64'(o_resp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_tid", 64'(o_resp_tid), 64'(e.tid));
        check("resp_data", o_resp_data, e.data);
        check("resp_cycle", 64'(cyc), 64'(e.due));
      end
    end
    if (int'(o_outstanding) > peak) peak = int'(o_outstanding);
    if (o_slv_rd_en) sl_q.push_back('{o_slv_rd_addr, cyc + lat});
    i_slv_rd_valid = 1'b0;
    if (!silent && sl_q.size() > 0 && sl_q[0].due <= cyc) begin
      s = sl_q.pop_front();
      i_slv_rd_valid = 1'b1;
      i_slv_rd_data  = mkdata(s.addr);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input logic [8:0] tid, input logic [15:0] addr, input bit acc,
                       input bit zero, input int due_off);
    step();
    i_req_valid = 1'b1;
    i_req_tid   = tid;
    i_req_addr  = addr;
    if (acc) sb.push_back('{tid, zero ? 64'd0 : mkdata(addr), cyc + due_off});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_slv_rd_en"}, 64'(o_slv_rd_en), 64'd0);
    check({tag, "_resp_valid"}, 64'(o_resp_valid), 64'd0);
    check({tag, "_resp_tid"}, 64'(o_resp_tid), 64'd0);
    check({tag, "_resp_data"}, o_resp_data, 64'd0);
    check({tag, "_outstanding"}, 64'(o_outstanding), 64'd0);
    check({tag, "_timeout_cnt"}, 64'(o_timeout_cnt), 64'd0);
    check({tag, "_overflow"}, 64'(o_overflow), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_tid = '0; i_req_addr = '0;
    i_slv_rd_valid = 1'b0; i_slv_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Single read, slave latency 3.
    lat = 3;
    issue(9'h015, 16'h0030, 1'b1, 1'b0, 5);
    drain(8);
    check("single_drained", 64'(sb.size()), 64'd0);

    // 64 back-to-back reads, slave latency 2.
    lat = 2;
    peak = 0;
    for (int i = 0; i < 64; i++) issue(9'(i), 16'(i * 4), 1'b1, 1'b0, 4);
    drain(10);
    check("b2b_drained", 64'(sb.size()), 64'd0);
    check("b2b_peak_le3", 64'(peak <= 3), 64'd1);
    check("b2b_overflow", 64'(o_overflow), 64'd0);

    // Timeout with a silent slave, then the late data must be swallowed.
    silent = 1'b1;
    issue(9'h077, 16'h0100, 1'b1, 1'b1, 17);
    exp_to++;
    drain(20);
    check("to_timeout_cnt", 64'(o_timeout_cnt), 64'(exp_to));
    silent = 1'b0;
    drain(6);
    check("to_drained", 64'(sb.size()), 64'd0);
    check("to_outstanding", 64'(o_outstanding), 64'd0);

    // Slave data lands on the expiry cycle: normal response, no timeout.
    lat = 15;
    issue(9'h1A2, 16'h0200, 1'b1, 1'b0, 17);
    drain(20);
    check("tie_timeout_cnt", 64'(o_timeout_cnt), 64'(exp_to));
    lat = 2;
    issue(9'h0AA, 16'h0204, 1'b1, 1'b0, 4);
    drain(6);
    check("tie_drained", 64'(sb.size()), 64'd0);

    // Overflow: four fill the FIFO, the fifth is dropped, all four time out.
    silent = 1'b1;
    for (int k = 0; k < 5; k++) issue(9'(9'h100 + k), 16'(16'h0400 + k), k < 4, 1'b1, 17 + 15 * k);
    step();
    check("ovf_flag", 64'(o_overflow), 64'd1);
    check("ovf_outstanding", 64'(o_outstanding), 64'd4);
    exp_to += 4;
    drain(80);
    check("ovf_drained", 64'(sb.size()), 64'd0);
    check("ovf_timeout_cnt", 64'(o_timeout_cnt), 64'(exp_to));
    silent = 1'b0;
    drain(8);
    issue(9'h0BB, 16'h0208, 1'b1, 1'b0, 4);
    drain(6);
    check("post_discard_drained", 64'(sb.size()), 64'd0);
    check("ovf_sticky", 64'(o_overflow), 64'd1);

    // Reset with requests pending: nothing may be answered afterwards.
    silent = 1'b1;
    issue(9'h0C1, 16'h0300, 1'b0, 1'b0, 0);
    issue(9'h0C2, 16'h0304, 1'b0, 1'b0, 0);
    drain(2);
    check("pre_rst_outstanding", 64'(o_outstanding), 64'd2);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    drain(3);
    rst = 1'b0;
    silent = 1'b0;
    drain(10);
    check("post_rst_outstanding", 64'(o_outstanding), 64'd0);
    check("post_rst_sl_empty", 64'(sl_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
